// File: rtl/slot_rr_scheduler_pkg.sv
// Shared types and sizing helpers for the slot round-robin scheduler.
package slot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 6;

  // Pointer/index width; a single requester still needs one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slot_rr_scheduler_rr_pick.sv
// Combinational circular priority search: first set req bit at or after start.
module rr_pick #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  int         c;
  logic [W-1:0] cidx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    cidx  = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(start) + i;
      if (c >= N) c = c - N;
      cidx = W'(c);
      if (!found && req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
  end

endmodule

// File: rtl/slot_rr_scheduler.sv
// Round-robin owner scheduler with bounded tenure and a guard gap between owners.
module slot_rr_scheduler
  import slot_sched_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int MAX_HOLD   = 4,
  parameter int GAP_CYCLES = 1,
  localparam int PW        = ptr_w(NUM_REQ),
  localparam int HW        = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_id,
  output logic               busy,
  output logic [PW-1:0]      slot_ptr
);

  state_t          state, state_nx;
  logic [HW-1:0]   hold_cnt;
  logic [2:0]      gap_cnt;
  logic            found;
  logic [PW-1:0]   pick_idx;
  logic            owner_req;
  logic            rel;
  logic            gap_end;
  logic [PW-1:0]   ptr_nx;

  rr_pick #(.N(NUM_REQ), .W(PW)) u_pick (
    .req   (req),
    .start (slot_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // grant is one-hot on the owner while in GRANT, so this is req[grant_id].
  assign owner_req = |(req & grant);
  assign rel       = done | ~owner_req | (hold_cnt == HW'(MAX_HOLD));
  assign gap_end   = (gap_cnt == 3'(GAP_CYCLES));
  assign ptr_nx    = (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found)   state_nx = GRANT;
      GRANT:   if (rel)     state_nx = GAP;
      GAP:     if (gap_end) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      grant_id <= '0;
      slot_ptr <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant    <= NUM_REQ'(1) << pick_idx;
            grant_id <= pick_idx;
            hold_cnt <= HW'(1);
          end
        end
        GRANT: begin
          if (rel) begin
            grant    <= '0;
            slot_ptr <= ptr_nx;
            gap_cnt  <= 3'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (!gap_end) gap_cnt <= gap_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/slot_rr_scheduler.md
Name: slot_rr_scheduler

Overview:
- Round-robin scheduler that shares one resource between NUM_REQ requesters (default 6).
- Uses a wrapping mod-NUM_REQ slot pointer, the same 0..5 sequence as our state-transition counter.
- Grants exactly one owner at a time and bounds each tenure with a hold limit.
- Inserts a guard gap between tenures.
- Sits between the requester blocks and the shared datapath, and drives its one-hot select.

Parameters:
- NUM_REQ, 6, number of requesters; pointer wraps NUM_REQ-1 -> 0.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure (1..15).
- GAP_CYCLES, 1, idle cycles with no grant between tenures (1..7).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- done  input  1  owner's end-of-use pulse; only valid while a grant is active.
- grant  output  NUM_REQ  registered one-hot grant; all zeros when idle.
- grant_id  output  $clog2(NUM_REQ)  index of the current owner; holds its last value when idle.
- busy  output  1  high while in GRANT or GAP.
- slot_ptr  output  $clog2(NUM_REQ)  search start pointer for the next arbitration.

Behaviour:
- Reset (async assert, any state, including mid-grant):
  - grant=0, grant_id=0, slot_ptr=0, busy=0.
  - hold_cnt=0, gap_cnt=0, state=IDLE.
  - Outputs change immediately, without waiting for clk.
- States: IDLE, GRANT, GAP.
- IDLE:
  - At a clk edge with |req=1, pick the winner as the first set req bit scanning slot_ptr, slot_ptr+1, ... circularly (mod NUM_REQ).
  - Load grant=onehot(winner), grant_id=winner, hold_cnt=1, go to GRANT.
  - Latency: req seen at edge N produces grant valid after edge N.
  - With req=0, stay in IDLE.
- GRANT, release condition at an edge = done | ~req[grant_id] | (hold_cnt==MAX_HOLD):
  - Release: grant<=0, slot_ptr<=(grant_id==NUM_REQ-1)?0:grant_id+1, gap_cnt<=1, go to GAP.
  - Otherwise: hold_cnt<=hold_cnt+1, grant unchanged.
  - Simultaneous release causes (done with timeout, done with req drop) produce one release and one gap.
- GAP:
  - grant stays 0 and req is ignored.
  - When gap_cnt==GAP_CYCLES, go to IDLE; else gap_cnt++.
  - Requests pending on GAP exit are arbitrated at the next edge in IDLE, so the worst-case turnaround is GAP_CYCLES+1 cycles.
- Forced release at MAX_HOLD leaves the owner's req high. The owner re-competes from the advanced pointer and loses to any other pending requester.
- A sole requester is regranted after each gap, because the circular scan wraps back to it.
- done while IDLE or in GAP is ignored.
- Invariant: $onehot0(grant) in every cycle, and grant!=0 only in GRANT.
- Counter widths: hold_cnt is $clog2(MAX_HOLD+1) bits, gap_cnt is 3 bits; neither counter ever exceeds its limit.

Decomposition:
- Package slot_sched_pkg holds:
  - the state enum (IDLE, GRANT, GAP);
  - default NUM_REQ=6;
  - the pointer-width localparam function.
- One sub-module, rr_pick: combinational circular priority search. Inputs req and start pointer; outputs found and index. It is unit-tested separately.

Test Plan:
- Reset with req=6'h3F held, then deassert reset -> grant=0 during reset; grant=6'b000001 and grant_id=0 after the first edge; slot_ptr=0.
- Only req[3] high continuously, done never pulsed -> grant[3] for 4 cycles, 1 gap cycle with grant=0, grant[3] again; slot_ptr=4 after each release.
- req=6'h3F, done pulsed each grant's first cycle -> grant order 0,1,2,3,4,5,0, each tenure 1 cycle with a 1-cycle gap.
- Owner 5 releases by dropping req[5] while req=6'b000011 -> slot_ptr wraps to 0, next grant=6'b000001.
- done asserted on the same edge as hold_cnt==4 -> exactly one release, gap of exactly 1 cycle, no double advance of slot_ptr.
- reset pulsed asynchronously mid-GRANT with owner 2 -> grant=0 before the next clk edge; after release, arbitration restarts from slot_ptr=0.
